// File: rtl/led_blink_bank.sv
// Bank of independent LED channels (off/on/blink/pulse) that share one base-tick prescaler.
// Each channel's blink half-period or pulse length is 2^rate base ticks.
module led_blink_bank #(
    parameter int unsigned N_CH    = 8,
    parameter int unsigned CNT_MAX = 25_000_000,
    parameter int unsigned RATE_W  = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [2*N_CH-1:0]        mode,
    input  logic [RATE_W*N_CH-1:0]   rate,
    input  logic [N_CH-1:0]          trig,
    output logic [N_CH-1:0]          led,
    output logic                     tick
);

    localparam int unsigned PW = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned CW = 2 ** RATE_W;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_PULSE = 2'b11
    } mode_t;

    logic [PW-1:0]   presc_q;
    logic            tick_q;
    mode_t           mode_q [N_CH];
    logic [CW-1:0]   cnt_q  [N_CH];
    logic [CW-1:0]   cnt_d  [N_CH];
    logic [N_CH-1:0] hist_q;
    logic [N_CH-1:0] led_q;
    logic [N_CH-1:0] led_d;

    // Terminal count for a rate exponent: 2^r - 1 ticks.
    function automatic logic [CW-1:0] lim_of(input logic [RATE_W-1:0] r);
        return (CW'(1) << r) - CW'(1);
    endfunction

    // Shared prescaler; tick is registered one cycle ahead so it is high while presc == CNT_MAX-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            if (presc_q == PW'(CNT_MAX - 1)) begin
                presc_q <= '0;
            end else begin
                presc_q <= presc_q + PW'(1);
            end
            tick_q <= (presc_q == PW'(CNT_MAX - 2));
        end
    end

    // Per-channel next-state: a mode change restarts the channel, otherwise run the mode.
    always_comb begin
        cnt_d = cnt_q;
        led_d = led_q;
        for (int i = 0; i < N_CH; i++) begin
            if (mode[2*i +: 2] != mode_q[i]) begin
                cnt_d[i] = '0;
                led_d[i] = (mode[2*i +: 2] == MODE_ON);
            end else begin
                case (mode_q[i])
                    MODE_OFF: led_d[i] = 1'b0;
                    MODE_ON:  led_d[i] = 1'b1;
                    MODE_BLINK: begin
                        if (tick_q) begin
                            if (cnt_q[i] >= lim_of(rate[RATE_W*i +: RATE_W])) begin
                                led_d[i] = ~led_q[i];
                                cnt_d[i] = '0;
                            end else begin
                                cnt_d[i] = cnt_q[i] + CW'(1);
                            end
                        end
                    end
                    MODE_PULSE: begin
                        // A fresh trigger edge beats a coincident tick and restarts the length.
                        if (trig[i] && !hist_q[i]) begin
                            led_d[i] = 1'b1;
                            cnt_d[i] = '0;
                        end else if (led_q[i] && tick_q) begin
                            if (cnt_q[i] >= lim_of(rate[RATE_W*i +: RATE_W])) begin
                                led_d[i] = 1'b0;
                                cnt_d[i] = '0;
                            end else begin
                                cnt_d[i] = cnt_q[i] + CW'(1);
                            end
                        end
                    end
                endcase
            end
        end
    end

    // Channel state; trig history resets high so a trig held through reset cannot fire.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_q  <= '0;
            hist_q <= '1;
            for (int i = 0; i < N_CH; i++) begin
                mode_q[i] <= MODE_OFF;
                cnt_q[i]  <= '0;
            end
        end else begin
            led_q  <= led_d;
            hist_q <= trig;
            for (int i = 0; i < N_CH; i++) begin
                mode_q[i] <= mode_t'(mode[2*i +: 2]);
                cnt_q[i]  <= cnt_d[i];
            end
        end
    end

    assign led  = led_q;
    assign tick = tick_q;

endmodule

// File: tb/tb_led_blink_bank.sv
// Directed bench for led_blink_bank with CNT_MAX=4; tick-action edges fall on every 4th edge after release.
module tb_led_blink_bank;

    logic        clk;
    logic        rst;
    logic [15:0] mode;
    logic [23:0] rate;
    logic [7:0]  trig;
    logic [7:0]  led;
    logic        tick;

    int checks;
    int errors;
    int ed;

    led_blink_bank #(.N_CH(8), .CNT_MAX(4), .RATE_W(3)) dut (
        .clk  (clk),
        .rst  (rst),
        .mode (mode),
        .rate (rate),
        .trig (trig),
        .led  (led),
        .tick (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the falling edge after rising edge number e since reset release.
    task automatic to(input int e);
        while (ed < e) begin
            @(negedge clk);
            ed++;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        ed     = 0;
        rst    = 1'b1;
        mode   = '0;
        rate   = '0;
        trig   = '0;
        repeat (3) @(negedge clk);
        chk("rst_led", 32'(led), 32'h00);
        chk("rst_tick", 32'(tick), 32'h0);
        rst = 1'b0;

        to(1);  chk("tick_e1", 32'(tick), 32'h0);
        to(2);  chk("tick_e2", 32'(tick), 32'h0);
        to(3);  chk("tick_e3", 32'(tick), 32'h1);
        chk("led_idle", 32'(led), 32'h00);
        to(4);  chk("tick_e4", 32'(tick), 32'h0);
        to(7);  chk("tick_e7", 32'(tick), 32'h1);

        // ch0 blink r=0, ch1 blink r=2, entering at edge 9
        to(8);
        mode[1:0] = 2'b10; rate[2:0] = 3'd0;
        mode[3:2] = 2'b10; rate[5:3] = 3'd2;
        to(9);  chk("blink_entry", 32'(led), 32'h00);
        to(11); chk("ch0_pre_tick", 32'(led[0]), 32'h0);
        to(12); chk("ch0_first_toggle", 32'(led[0]), 32'h1);
        chk("ch1_no_toggle", 32'(led[1]), 32'h0);
        to(15); chk("ch0_high4", 32'(led[0]), 32'h1);
        to(16); chk("ch0_low", 32'(led[0]), 32'h0);
        to(20); trig[3] = 1'b1;
        to(21); trig[3] = 1'b0;
        to(22); chk("ch3_trig_ignored", 32'(led[3]), 32'h0);
        to(23); chk("ch1_pre_toggle", 32'(led[1]), 32'h0);
        to(24); chk("led_e24", 32'(led), 32'h02);
        to(39); chk("ch1_high16", 32'(led[1]), 32'h1);
        to(40); chk("ch1_low", 32'(led[1]), 32'h0);

        // ch0 blink -> on -> blink mid-period
        to(42); mode[1:0] = 2'b01;
        to(43); chk("ch0_on", 32'(led[0]), 32'h1);
        to(44); mode[1:0] = 2'b10;
        to(45); chk("ch0_reblink", 32'(led[0]), 32'h0);
        to(47); chk("ch0_reblink_hold", 32'(led[0]), 32'h0);
        to(48); chk("ch0_reblink_toggle", 32'(led[0]), 32'h1);

        // ch1 rate drop with counter already past the new limit
        to(52); rate[5:3] = 3'd0;
        to(55); chk("ch1_rate_hold", 32'(led[1]), 32'h0);
        to(56); chk("ch1_rate_toggle", 32'(led[1]), 32'h1);

        // ch2 pulse r=1
        mode[5:4] = 2'b11; rate[8:6] = 3'd1;
        to(57); chk("ch2_entry", 32'(led[2]), 32'h0);
        to(58); trig[2] = 1'b1;
        to(59); trig[2] = 1'b0;
        chk("pulse_start", 32'(led[2]), 32'h1);
        to(63); chk("pulse_hold", 32'(led[2]), 32'h1);
        to(64); chk("pulse_end", 32'(led[2]), 32'h0);

        // trig held high: a single pulse only
        to(65); trig[2] = 1'b1;
        to(66); chk("held_start", 32'(led[2]), 32'h1);
        to(72); chk("held_end", 32'(led[2]), 32'h0);
        to(80); chk("held_no_retrig", 32'(led[2]), 32'h0);
        trig[2] = 1'b0;

        // retrigger one tick into the pulse
        to(81); trig[2] = 1'b1;
        to(82); trig[2] = 1'b0;
        to(85); trig[2] = 1'b1;
        to(86); trig[2] = 1'b0;
        to(88); chk("retrig_extend", 32'(led[2]), 32'h1);
        to(91); chk("retrig_hold", 32'(led[2]), 32'h1);
        to(92); chk("retrig_end", 32'(led[2]), 32'h0);

        // retrigger coincident with a tick-action edge
        to(93);  trig[2] = 1'b1;
        to(94);  trig[2] = 1'b0;
        to(99);  trig[2] = 1'b1;
        to(100); trig[2] = 1'b0;
        chk("coinc_lit", 32'(led[2]), 32'h1);
        to(104); chk("coinc_cnt0", 32'(led[2]), 32'h1);
        to(107); chk("coinc_hold", 32'(led[2]), 32'h1);
        to(108); chk("coinc_end", 32'(led[2]), 32'h0);

        // asynchronous reset while ch0 is lit and tick is high
        to(115);
        chk("pre_rst_led0", 32'(led[0]), 32'h1);
        chk("pre_rst_tick", 32'(tick), 32'h1);
        trig[2] = 1'b1;
        #1 rst = 1'b1;
        #1;
        chk("async_led", 32'(led), 32'h00);
        chk("async_tick", 32'(tick), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ed  = 0;
        to(1);  chk("rel_e1", 32'(led), 32'h00);
        to(3);  chk("rel_tick", 32'(tick), 32'h1);
        chk("rel_e3", 32'(led), 32'h00);
        to(4);  chk("rel_e4", 32'(led), 32'h03);
        to(8);  chk("rel_e8", 32'(led), 32'h00);
        to(12); chk("rel_e12", 32'(led), 32'h03);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_blink_bank.md
LED_BLINK_BANK -- requirements
Module: led_blink_bank

Interface
REQ-001 SHALL have parameter N_CH, default 8: number of independent LED channels (1..32).
REQ-002 SHALL have parameter CNT_MAX, default 25_000_000: clk cycles per base tick (>=2; benches use 4).
REQ-003 SHALL have parameter RATE_W, default 3: width of each channel's rate field.
REQ-004 SHALL have port: clk  input  1  system clock; all state on rising edge.
REQ-005 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port: mode  input  2*N_CH  per-channel mode, channel i at [2i+1:2i]: 00 off, 01 on, 10 blink, 11 pulse.
REQ-007 SHALL have port: rate  input  RATE_W*N_CH  per-channel exponent r; half-period/pulse length = 2^r ticks.
REQ-008 SHALL have port: trig  input  N_CH  per-channel pulse trigger, level, synchronous to clk.
REQ-009 SHALL have port: led  output  N_CH  registered LED drive, 1 = lit.
REQ-010 SHALL have port: tick  output  1  base tick strobe, one cycle wide.

Function
REQ-011 Prescaler SHALL count 0..CNT_MAX-1 and wrap; tick SHALL be 1 exactly while prescaler == CNT_MAX-1 (one cycle in every CNT_MAX).
REQ-012 Prescaler SHALL be shared by all channels and never reset by mode, rate or trig activity.
REQ-013 Each channel SHALL own a tick counter of width 2^RATE_W bits, a registered mode copy, a trig history bit and its led register.
REQ-014 Mode change on channel i (mode differs from registered copy) SHALL clear its counter and, on the same edge, load led: off->0, on->1, blink->0, pulse->0.
REQ-015 Off: led 0; on: led 1; both SHALL appear one clk edge after mode is applied.
REQ-016 Blink: on each tick, counter == 2^r-1 -> led toggles, counter clears; otherwise counter increments.
REQ-017 Blink: led SHALL toggle on the 2^r-th tick after entry, then every 2^r ticks (full period 2^(r+1) ticks).
REQ-018 Pulse: rising edge = trig & ~history; on edge led SHALL be 1 on the next edge and counter cleared.
REQ-019 Pulse: while led 1, each tick increments counter; on the 2^r-th tick led SHALL return to 0.
REQ-020 Pulse retrigger while lit SHALL clear counter (length restarts); edge and tick on same cycle: edge wins, counter = 0.
REQ-021 Trig held high or level-only SHALL not retrigger; trig edges in modes other than pulse SHALL be ignored (history still updated).
REQ-022 Rate change without mode change SHALL take effect at the next counter comparison, without clearing the counter; if counter already > 2^r-1, the next tick SHALL perform the toggle/end action and clear.
REQ-023 Channels SHALL be fully independent; same mode/rate/entry cycle SHALL yield identical led waveforms.

Reset
REQ-024 rst high SHALL immediately force led = 0, tick = 0, prescaler = 0, all counters = 0, registered modes = 00.
REQ-025 Trig history SHALL reset to all 1s, so trig held high across reset release SHALL not fire a pulse.
REQ-026 Reset asserted mid-blink or mid-pulse SHALL abort it; after release channels restart per REQ-014 (mode differs from reset copy 00) on the first edge.
REQ-027 First tick after release SHALL occur CNT_MAX-1 edges after release.

Verification (CNT_MAX=4, N_CH=8, RATE_W=3)
REQ-028 Release rst, all modes 00 -> led = 0x00; tick high one cycle every 4 cycles, first after 3 edges.
REQ-029 ch0 mode 10, rate 0 -> led[0] toggles each tick: high 4 cycles, low 4 cycles; ch1 rate 2 -> 16 high/16 low.
REQ-030 ch2 mode 11, rate 1, one-cycle trig pulse -> led[2] = 1 next edge, returns 0 on 2nd subsequent tick; trig held high -> single pulse only.
REQ-031 ch2 retrigger one tick into pulse -> led[2] stays 1 for 2 more ticks from retrigger; edge coincident with tick -> counter 0, not 1.
REQ-032 Assert rst mid-blink (led[0]=1) -> led[0]=0 same cycle, no clk edge needed; release with trig[2]=1, mode 11 -> no pulse.
REQ-033 Switch ch0 10->01 mid-period -> led[0]=1 next edge; 01->10 -> led[0]=0 next edge, first toggle on 2^r-th tick after.
